// File: rtl/mem_pkg.sv
// mem_pkg: funct3 codes, FSM states and access-size helper shared by the memory-stage unit
package mem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
  // Access size: 0 byte, 1 half, 2 word. Unsigned codes only size loads; stores treat them as word.
  function automatic logic [1:0] acc_size(input logic [2:0] f3, input logic wr);
    return (f3 == F3_LB || (!wr && f3 == F3_LBU)) ? 2'd0 :
           (f3 == F3_LH || (!wr && f3 == F3_LHU)) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/load_formatter.sv
// load_formatter: selects and sign/zero-extends the loaded byte/half/word from a bus read word
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);
  logic [7:0]  b;
  logic [15:0] h;
  // Lane select then extension; reserved codes fall through to full word
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    value = funct3 == F3_LB  ? {{24{b[7]}}, b} :
            funct3 == F3_LH  ? {{16{h[15]}}, h} :
            funct3 == F3_LBU ? {24'b0, b} :
            funct3 == F3_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store bus sequencer with stall; MEM_MISALIGN_TRAP_EN turns misaligned accesses into a MisalignM_out pulse instead of an aligned access
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM_in,
  input  logic [31:0] WriteDataM_in,
  input  logic [2:0]  funct3M_in,
  input  logic        MemReadM_in,
  input  logic        MemWriteM_in,
  input  logic        ValidM_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_wstrb_out,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ready_in,
  output logic        StallM_out,
  output logic [31:0] ReadDataW_out,
  output logic        MisalignM_out
);
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  state_t      state;
  logic        access, wr, mis;
  logic [1:0]  size, off, off_q;
  logic [2:0]  f3_q;
  logic [3:0]  strb;
  logic [31:0] wdata, fmt;
  // Decode the incoming access; the lane offset is forced to natural alignment for its size
  always_comb begin
    access = ValidM_in & (MemReadM_in | MemWriteM_in);
    wr     = MemWriteM_in;
    size   = acc_size(funct3M_in, wr);
    off    = ALUResultM_in[1:0] & (size == 2'd0 ? 2'b11 : size == 2'd1 ? 2'b10 : 2'b00);
    mis    = (size == 2'd1 && ALUResultM_in[0]) || (size == 2'd2 && ALUResultM_in[1:0] != 2'b00);
    strb   = size == 2'd0 ? 4'b0001 << off : size == 2'd1 ? 4'b0011 << off : 4'b1111;
    wdata  = size == 2'd0 ? {4{WriteDataM_in[7:0]}} :
             size == 2'd1 ? {2{WriteDataM_in[15:0]}} : WriteDataM_in;
  end
  load_formatter u_fmt (
    .rdata  (mem_rdata_in),
    .off    (off_q),
    .funct3 (f3_q),
    .value  (fmt)
  );
  // Stall while detecting an access and throughout the bus request; RESP lets the instruction advance
  always_comb StallM_out = !rst && ((state == ST_IDLE && access) || state == ST_REQ);
  // Transaction FSM with registered bus outputs, load result and misalign pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_wstrb_out <= '0;
      ReadDataW_out <= '0;
      MisalignM_out <= 1'b0;
      off_q         <= '0;
      f3_q          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          MisalignM_out <= 1'b0;
          if (access && TRAP_EN && mis) begin
            state         <= ST_RESP;
            MisalignM_out <= 1'b1;
          end else if (access) begin
            state         <= ST_REQ;
            mem_req_out   <= 1'b1;
            mem_we_out    <= wr;
            mem_addr_out  <= {ALUResultM_in[31:2], 2'b00};
            mem_wdata_out <= wdata;
            mem_wstrb_out <= wr ? strb : 4'b0000;
            off_q         <= off;
            f3_q          <= funct3M_in;
          end
        end
        ST_REQ: if (mem_ready_in) begin
          state       <= ST_RESP;
          mem_req_out <= 1'b0;
          if (!mem_we_out) ReadDataW_out <= fmt;
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          MisalignM_out <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0, rst;
  logic [31:0] ALUResultM_in, WriteDataM_in, mem_addr_out, mem_wdata_out, mem_rdata_in, ReadDataW_out;
  logic [2:0]  funct3M_in;
  logic        MemReadM_in, MemWriteM_in, ValidM_in, mem_req_out, mem_we_out, mem_ready_in;
  logic        StallM_out, MisalignM_out;
  logic [3:0]  mem_wstrb_out;
  int          n_tests = 0, n_fail = 0;
  int          stalls, reqs;
  bit          done;
  logic        c_we, r_req, r_mis;
  logic [3:0]  c_wstrb;
  logic [31:0] c_addr, c_wdata, r_rdw;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .ALUResultM_in(ALUResultM_in), .WriteDataM_in(WriteDataM_in),
    .funct3M_in(funct3M_in), .MemReadM_in(MemReadM_in), .MemWriteM_in(MemWriteM_in),
    .ValidM_in(ValidM_in), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out), .mem_wstrb_out(mem_wstrb_out),
    .mem_rdata_in(mem_rdata_in), .mem_ready_in(mem_ready_in), .StallM_out(StallM_out),
    .ReadDataW_out(ReadDataW_out), .MisalignM_out(MisalignM_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic [2:0] f3, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdat, input int waits);
    int w = 0;
    funct3M_in = f3; MemReadM_in = rd; MemWriteM_in = wr; ALUResultM_in = addr;
    WriteDataM_in = wd; ValidM_in = 1'b1; mem_rdata_in = rdat; mem_ready_in = 1'b0;
    stalls = 0; reqs = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!StallM_out) begin
        done = 1; r_req = mem_req_out; r_mis = MisalignM_out; r_rdw = ReadDataW_out;
        ValidM_in = 1'b0; mem_ready_in = 1'b0;
      end else begin
        stalls++;
        if (mem_req_out) begin
          reqs++;
          c_addr = mem_addr_out; c_we = mem_we_out; c_wdata = mem_wdata_out; c_wstrb = mem_wstrb_out;
          mem_ready_in = (w == waits);
          w++;
        end
        @(posedge clk); #1;
      end
    end
    if (!done) check("timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; ALUResultM_in = '0; WriteDataM_in = '0; funct3M_in = '0; mem_rdata_in = '0;
    MemReadM_in = 1'b1; MemWriteM_in = 1'b0; ValidM_in = 1'b1; mem_ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(StallM_out), 32'd0);
    check("rst_req", 32'(mem_req_out), 32'd0);
    check("rst_addr", mem_addr_out, 32'h0);
    check("rst_rdw", ReadDataW_out, 32'h0);
    check("rst_mis", 32'(MisalignM_out), 32'd0);
    check("rst_wstrb", 32'(mem_wstrb_out), 32'd0);
    ValidM_in = 1'b0; MemReadM_in = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    mem_ready_in = 1'b1;
    @(posedge clk); #1;
    check("ready_idle_req", 32'(mem_req_out), 32'd0);
    check("ready_idle_rdw", ReadDataW_out, 32'h0);
    mem_ready_in = 1'b0;

    access(3'b000, 1, 0, 32'h103, 32'h0, 32'h80FF_1234, 0);
    check("lb_rdw", r_rdw, 32'hFFFF_FF80);
    check("lb_stalls", stalls, 2);
    check("lb_reqs", reqs, 1);
    check("lb_addr", c_addr, 32'h100);
    check("lb_we", 32'(c_we), 32'd0);
    check("lb_wstrb", 32'(c_wstrb), 32'd0);
    check("lb_resp_req", 32'(r_req), 32'd0);

    access(3'b101, 1, 0, 32'h102, 32'h0, 32'hBEEF_0001, 3);
    check("lhu_rdw", r_rdw, 32'h0000_BEEF);
    check("lhu_stalls", stalls, 5);
    check("lhu_reqs", reqs, 4);

    access(3'b001, 1, 0, 32'h102, 32'h0, 32'hBEEF_0001, 0);
    check("lh_rdw", r_rdw, 32'hFFFF_BEEF);

    access(3'b100, 1, 0, 32'h101, 32'h0, 32'h80FF_1234, 1);
    check("lbu_rdw", r_rdw, 32'h0000_0012);
    check("lbu_stalls", stalls, 3);

    access(3'b000, 0, 1, 32'h201, 32'h0000_00A5, 32'h0, 0);
    check("sb_we", 32'(c_we), 32'd1);
    check("sb_addr", c_addr, 32'h200);
    check("sb_wdata", c_wdata, 32'hA5A5_A5A5);
    check("sb_wstrb", 32'(c_wstrb), 32'b0010);
    check("sb_rdw_hold", r_rdw, 32'h0000_0012);

    access(3'b010, 1, 0, 32'h300, 32'h0, 32'h1111_1111, 0);
    check("lw_rdw", r_rdw, 32'h1111_1111);
    check("lw_resp_req", 32'(r_req), 32'd0);
    access(3'b001, 0, 1, 32'h302, 32'h0000_BEAD, 32'h0, 0);
    check("sh_wstrb", 32'(c_wstrb), 32'b1100);
    check("sh_wdata", c_wdata, 32'hBEAD_BEAD);
    check("sh_addr", c_addr, 32'h300);
    check("sh_stalls", stalls, 2);
    check("sh_rdw_hold", r_rdw, 32'h1111_1111);

    access(3'b010, 1, 1, 32'h400, 32'hDEAD_BEEF, 32'h0, 0);
    check("both_we", 32'(c_we), 32'd1);
    check("both_wstrb", 32'(c_wstrb), 32'b1111);
    check("both_wdata", c_wdata, 32'hDEAD_BEEF);

    access(3'b010, 0, 0, 32'h500, 32'h0, 32'h0, 0);
    check("nonmem_stalls", stalls, 0);
    check("nonmem_reqs", reqs, 0);

    access(3'b010, 1, 0, 32'h106, 32'h0, 32'hCAFE_F00D, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_reqs", reqs, 0);
    check("mis_pulse", 32'(r_mis), 32'd1);
    check("mis_stalls", stalls, 1);
    check("mis_rdw", r_rdw, 32'h1111_1111);
    check("mis_pulse_end", 32'(MisalignM_out), 32'd0);
`else
    check("mis_addr", c_addr, 32'h104);
    check("mis_flag", 32'(r_mis), 32'd0);
    check("mis_rdw", r_rdw, 32'hCAFE_F00D);
    check("mis_stalls", stalls, 2);
`endif

    funct3M_in = 3'b010; MemReadM_in = 1'b1; MemWriteM_in = 1'b0; ALUResultM_in = 32'h600;
    ValidM_in = 1'b1; mem_ready_in = 1'b0;
    @(posedge clk); #1;
    check("rstreq_req_before", 32'(mem_req_out), 32'd1);
    rst = 1'b1; ValidM_in = 1'b0;
    #1;
    check("rstreq_stall_during", 32'(StallM_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstreq_req", 32'(mem_req_out), 32'd0);
    check("rstreq_stall", 32'(StallM_out), 32'd0);
    check("rstreq_rdw", ReadDataW_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-memory access unit for the 5-stage RV32I pipeline. Takes the EX/MEM load/store controls, runs a single-outstanding request/ready transaction on the data-memory bus, and stalls the M stage until the transaction completes. It returns the aligned, sign- or zero-extended load value as `ReadDataW_out`, which feeds the write-back result select as its load-data input.

## Interface
Parameters:
- none; widths fixed at RV32 (32-bit address/data, 4 byte strobes).

Ports:
- Clocking is decided: one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous active-high reset
- `ALUResultM_in` in 32: byte address
- `WriteDataM_in` in 32: store data (rs2)
- `funct3M_in` in 3: access size/sign
- `MemReadM_in` in 1: load
- `MemWriteM_in` in 1: store (wins if both set)
- `ValidM_in` in 1: M-stage instruction valid (not bubble)
- `mem_req_out` out 1: bus request
- `mem_we_out` out 1: 1 = write
- `mem_addr_out` out 32: word address, bits [1:0] = 0
- `mem_wdata_out` out 32: lane-replicated store data
- `mem_wstrb_out` out 4: byte enables (0 on reads)
- `mem_rdata_in` in 32: read word, valid when `mem_ready_in`
- `mem_ready_in` in 1: transaction complete
- `StallM_out` out 1: hold F/D/E/M stages
- `ReadDataW_out` out 32: formatted load data for write-back
- `MisalignM_out` out 1: misaligned-access pulse

## Operation
FSM states are IDLE, REQ and RESP.
- **IDLE**:
  - An access is `ValidM_in & (MemReadM_in | MemWriteM_in)`.
  - On an access: latch addr/we/wdata/wstrb/funct3, go to REQ, `StallM_out`=1 (combinational).
  - With no access: `StallM_out`=0.
- **REQ**:
  - `mem_req_out`=1; bus outputs come from registers and are stable until ready.
  - `StallM_out`=1.
  - On `mem_ready_in`: if read, register the formatted `mem_rdata_in` into `ReadDataW_out`; go to RESP.
- **RESP**:
  - `StallM_out`=0 for exactly one cycle, so the instruction advances to WB.
  - No new access is accepted in this state; the next state is always IDLE.
- **Load format, by `funct3`:**
  - 000 LB: sign-extended byte[addr[1:0]]
  - 001 LH: sign-extended half[addr[1]]
  - 010 LW: full word
  - 100 LBU, 101 LHU: zero-extended
  - 011/110/111: treated as LW
- **Store, by `funct3`:**
  - SB: byte replicated ×4, strobe `4'b0001<<addr[1:0]`.
  - SH: half replicated ×2, strobe `4'b0011<<{addr[1],1'b0}`.
  - SW and all other codes: strobe `4'b1111`.
- **Misaligned**: halfword access with addr[0]=1, or word access with addr[1:0]≠0. See Configuration.
- `ReadDataW_out` holds its value until the next completed load, so it stays valid during the load's WB cycle.

## Timing
- **Reset**:
  - The state becomes IDLE at the reset edge.
  - `ReadDataW_out`, `MisalignM_out`, `mem_req_out`, `mem_we_out`, `mem_addr_out`, `mem_wdata_out` and `mem_wstrb_out` are all 0.
  - `StallM_out` is forced 0 while `rst`=1.
  - Reset in REQ abandons the transaction: `mem_req_out` drops after the edge.
- **Zero-wait access**:
  - C0 IDLE detect (stall).
  - C1 REQ, ready=1 (stall).
  - C2 RESP (no stall; `ReadDataW_out` valid).
  - Minimum 3 cycles per memory instruction.
- **Wait states**: each extra cycle with `mem_ready_in`=0 extends REQ by one cycle.
- **Sampling**: `mem_rdata_in` is sampled only in the REQ cycle where ready=1. `mem_ready_in` outside REQ is ignored.
- **Non-memory instructions**: pass with zero added latency.

## Configuration
Macro `MEM_MISALIGN_TRAP_EN`.
- **Defined**:
  - A misaligned access issues no bus request; IDLE goes directly to RESP.
  - `MisalignM_out`=1 during that RESP cycle only.
  - `ReadDataW_out` is unchanged.
- **Undefined**:
  - The misaligned low address bits are cleared to natural alignment and the access proceeds normally.
  - `MisalignM_out` is tied to 0.

## Structure
- Shared package `mem_pkg` holds:
  - funct3 constants: `F3_LB/LH/LW/LBU/LHU/SB/SH/SW`
  - FSM state encodings: `ST_IDLE/ST_REQ/ST_RESP`
- One sub-module, `load_formatter`, is combinational: (rdata, addr[1:0], funct3) → 32-bit extended value. It is reusable by a future forwarding path.

## Test plan
- LB, addr 0x103, rdata 0x80FF_1234, ready in first REQ cycle → `ReadDataW_out`=0xFFFF_FF80; stall high 2 cycles, low in C2.
- LHU, addr 0x102, rdata 0xBEEF_0001, 3 wait states → `ReadDataW_out`=0x0000_BEEF; stall high 5 cycles.
- SB, addr 0x201, data 0x0000_00A5 → `mem_we_out`=1, addr 0x200, wdata 0xA5A5_A5A5, wstrb 0010.
- Back-to-back LW (rdata 0x1111_1111) then SH (addr 0x302) → no request in the RESP cycle; second request starts 1 cycle after RESP; SH wstrb 1100.
- LW to 0x106: with `MEM_MISALIGN_TRAP_EN` → `mem_req_out` never asserted, 1-cycle `MisalignM_out`; without it → bus addr 0x104, `MisalignM_out`=0.
- `rst` asserted in REQ with ready=0 → next cycle IDLE, `mem_req_out`=0, `StallM_out`=0, `ReadDataW_out`=0.
